accumulator_readout_unit: RTL and testbench
===========================================

# accumulator_readout_unit

Drains finished result rows from the accumulator RAM and streams them to the unified-buffer write port over a valid/ready handshake. It sits on the read side of the accumulators, opposite the accumulator control unit that fills them. On each command it reads `num_rows_i` consecutive rows starting at `base_addr_i`. It absorbs the RAM's fixed read latency and downstream backpressure with a credit-controlled output FIFO, so no read data is ever dropped.

## Interface
- `MUL_SIZE`, 32, lanes per accumulator row (systolic array width).
- `ACC_WIDTH`, 32, bits per lane (signed).
- `ADDR_W`, 10, accumulator address width.
- `RD_LATENCY`, 2, cycles from `accumulator_rd_en_o` to valid `accumulator_data_i`; legal range 1..4.
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ `RD_LATENCY`+1, enforced by an elaboration-time `$error`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: command strobe; sampled only in IDLE.
- `base_addr_i` in `ADDR_W`: first row address; captured with `start_i`.
- `num_rows_i` in `ADDR_W`: rows to drain; captured with `start_i`.
- `busy_o` out 1: high from command accept until `done_o`, inclusive.
- `done_o` out 1: one-cycle pulse when the command completes.
- `accumulator_rd_en_o` out 1: RAM read strobe.
- `accumulator_addr_rd_o` out `ADDR_W`: RAM read address.
- `accumulator_data_i` in `MUL_SIZE*ACC_WIDTH`: RAM read data; lane 0 is in the LSBs.
- `out_valid_o` out 1: output beat valid.
- `out_ready_i` in 1: downstream ready.
- `out_data_o` out `MUL_SIZE*ACC_WIDTH`: output row.
- `out_row_o` out `ADDR_W`: row index of the beat within the command, 0-based.
- `out_last_o` out 1: marks the final beat of the command.

## Operation
- FSM states:
  - IDLE: on `start_i`, go to READ, or to DONE if `num_rows_i`==0. Latch the base address and row count, clear the issue and return counters.
  - READ: issue reads while credit allows. Go to DRAIN after the issue that makes issued == `num_rows`.
  - DRAIN: no reads are issued. Go to DONE when the handshake for the beat with `out_last_o` completes.
  - DONE: pulse `done_o`, then return to IDLE.
- Credit rule: a read issues in a cycle iff state==READ and `inflight + fifo_count - pop < FIFO_DEPTH`, where `pop` = `out_valid_o & out_ready_i`.
- `inflight` counts reads whose data has not yet returned. A `RD_LATENCY`-deep valid shift register tracks them.
- Read address is `base + issue_cnt`, modulo 2^`ADDR_W`, so 1023 wraps to 0.
- Returning data is written into the FIFO tagged with its row index. The tag for the row with index `num_rows`-1 sets `out_last_o`.
- FIFO is show-ahead: `out_data_o`, `out_row_o` and `out_last_o` are driven from the head entry.
- Simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.
- While `out_valid_o`=1 and `out_ready_i`=0, `out_data_o`, `out_row_o` and `out_last_o` hold stable.
- `start_i` in any state other than IDLE is ignored. No error is flagged.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset asserted mid-command aborts immediately: all in-flight data is discarded and no `done_o` is generated.
- With `start_i` accepted at cycle T:
  - first `accumulator_rd_en_o` at T+1;
  - first data captured at T+1+`RD_LATENCY`;
  - first `out_valid_o` at T+2+`RD_LATENCY`.
- With `out_ready_i` held at 1, reads issue on consecutive cycles, giving 1 row per cycle sustained.
- `done_o` pulses the cycle after the last handshake; `busy_o` falls the cycle after `done_o`.
- `num_rows_i`==0: `done_o` at T+1, with no reads and no beats.
- Back-to-back commands: the next `start_i` is accepted no earlier than the first cycle `busy_o`=0. Minimum gap is 1 idle cycle.

## Configuration
- `ACCUM_READOUT_RELU_EN`
  - Defined: each lane is treated as signed `ACC_WIDTH`. Negative values are replaced by 0 at FIFO write. The row index and the `out_last_o` tag are unaffected.
  - Undefined: data passes through bit-exact.
  - Latency is identical in both cases.

## Test plan
- Basic drain: base=0, rows=8, `out_ready_i`=1 throughout. Expect reads at T+1..T+8 with addresses 0..7, beats with rows 0..7 on 8 consecutive cycles from T+4, `out_last_o` on row 7, `done_o` at T+12.
- Backpressure: rows=16, `out_ready_i` toggling 1/0. Expect no lost or duplicated rows, data stable while stalled, FIFO count never above 4, and at most 4 reads outstanding-plus-buffered.
- Wrap: base=1020, rows=6. Expect read addresses 1020, 1021, 1022, 1023, 0, 1 and `out_row_o` 0..5.
- Zero length and ignored start: rows=0 gives `done_o` at T+1 with no `rd_en`. A second `start_i` pulsed mid-command changes nothing.
- Reset mid-command: assert `rst_i` after 3 beats of a 10-row command. Expect all outputs 0 asynchronously, no `done_o`, and a fresh command afterwards that completes correctly.
- ReLU: with `ACCUM_READOUT_RELU_EN` defined, lanes {-5, 7, 0x80000000, 0} read as {0, 7, 0, 0}. With it undefined, the same lanes pass through unchanged.

Source files
------------

// File: rtl/accumulator_readout_unit.sv
// Streams accumulator RAM rows to the unified-buffer write port through a credit-limited show-ahead FIFO.
// Optional macro ACCUM_READOUT_RELU_EN clamps negative lanes to zero at FIFO write.
module accumulator_readout_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [ADDR_W-1:0]               base_addr_i,
  input  logic [ADDR_W-1:0]               num_rows_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            accumulator_rd_en_o,
  output logic [ADDR_W-1:0]               accumulator_addr_rd_o,
  input  logic [MUL_SIZE*ACC_WIDTH-1:0]   accumulator_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [MUL_SIZE*ACC_WIDTH-1:0]   out_data_o,
  output logic [ADDR_W-1:0]               out_row_o,
  output logic                            out_last_o
);

  localparam int DW = MUL_SIZE * ACC_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_chk
    $error("accumulator_readout_unit: FIFO_DEPTH must be >= RD_LATENCY+1");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_chk
    $error("accumulator_readout_unit: RD_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   num_rows_q, num_rows_d;
  logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [DW-1:0]       mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   mem_row_q  [FIFO_DEPTH];
  logic                mem_last_q [FIFO_DEPTH];

  logic [CW-1:0]       inflight;
  logic                issue, push, pop, push_last;
  logic [DW-1:0]       push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both reads still in the RAM pipe and rows already buffered.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_sr_q[i]);
    pop   = out_valid_o & out_ready_i;
    push  = vld_sr_q[RD_LATENCY-1];
    issue = (state_q == READ) && ((inflight + count_q - CW'(pop)) < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_rows_q  <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      vld_sr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_rows_q  <= num_rows_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      vld_sr_q    <= vld_sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (num_rows_i == '0) ? DONE : READ;
      READ:    if (issue && (issue_cnt_q + ADDR_W'(1) == num_rows_q)) state_d = DRAIN;
      DRAIN:   if (pop && out_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    num_rows_d  = num_rows_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (state_q == IDLE && start_i) begin
      base_d      = base_addr_i;
      num_rows_d  = num_rows_i;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end
    if (issue) issue_cnt_d = issue_cnt_q + ADDR_W'(1);
    if (push)  ret_cnt_d   = ret_cnt_q + ADDR_W'(1);
    vld_sr_d = (vld_sr_q << 1) | RD_LATENCY'(issue);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    push_data = accumulator_data_i;
`ifdef ACCUM_READOUT_RELU_EN
    for (int l = 0; l < MUL_SIZE; l++) begin
      if (accumulator_data_i[l*ACC_WIDTH + ACC_WIDTH-1]) push_data[l*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`endif
    push_last = (ret_cnt_q == num_rows_q - ADDR_W'(1));
  end

  // Storage needs no reset: the entry count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_row_q[wr_ptr_q]  <= ret_cnt_q;
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

  always_comb begin
    busy_o                = (state_q != IDLE);
    done_o                = (state_q == DONE);
    accumulator_rd_en_o   = issue;
    accumulator_addr_rd_o = issue ? (base_q + issue_cnt_q) : '0;
    out_valid_o           = (count_q != '0);
    out_data_o            = out_valid_o ? mem_data_q[rd_ptr_q] : '0;
    out_row_o             = out_valid_o ? mem_row_q[rd_ptr_q]  : '0;
    out_last_o            = out_valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_accumulator_readout_unit.sv
// Directed self-checking bench for accumulator_readout_unit with a 2-cycle RAM model.
module tb_accumulator_readout_unit;

  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [9:0]    base_addr_i = '0;
  logic [9:0]    num_rows_i = '0;
  logic          busy_o, done_o, rd_en, out_valid_o, out_last_o;
  logic [9:0]    rd_addr, out_row_o;
  logic [DW-1:0] acc_data, out_data_o;
  logic          out_ready_i = 1'b1;
  logic          clr = 1'b0;

  int total = 0;
  int bad   = 0;

  accumulator_readout_unit dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .start_i              (start_i),
    .base_addr_i          (base_addr_i),
    .num_rows_i           (num_rows_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .accumulator_rd_en_o  (rd_en),
    .accumulator_addr_rd_o(rd_addr),
    .accumulator_data_i   (acc_data),
    .out_valid_o          (out_valid_o),
    .out_ready_i          (out_ready_i),
    .out_data_o           (out_data_o),
    .out_row_o            (out_row_o),
    .out_last_o           (out_last_o)
  );

  always #5 clk = ~clk;

  // Row contents: lane l of address a is {a, l}; address 500 holds the signed test lanes.
  function automatic logic [DW-1:0] rowData(input int addr);
    logic [DW-1:0] r;
    r = '0;
    if (addr == 500) begin
      r[31:0]  = 32'hFFFF_FFFB;
      r[63:32] = 32'h0000_0007;
      r[95:64] = 32'h8000_0000;
    end else begin
      for (int l = 0; l < 32; l++) r[l*32 +: 32] = {16'(addr), 16'(l)};
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] reluRowExpect();
    logic [DW-1:0] r;
    r = '0;
`ifdef ACCUM_READOUT_RELU_EN
    r[63:32] = 32'h0000_0007;
`else
    r[31:0]  = 32'hFFFF_FFFB;
    r[63:32] = 32'h0000_0007;
    r[95:64] = 32'h8000_0000;
`endif
    return r;
  endfunction

  logic [9:0] p1_addr = '0, p2_addr = '0;
  always @(posedge clk) begin
    p1_addr <= rd_addr;
    p2_addr <= p1_addr;
  end
  assign acc_data = rowData(int'(p2_addr));

  // Monitor: records reads, beats and done pulses with their cycle numbers.
  int            cyc = 0;
  int            start_cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            occ = 0;
  int            max_occ = 0;
  int            stall_err = 0;
  int            rd_addr_q[$];
  int            rd_cyc_q[$];
  int            beat_row_q[$];
  int            beat_cyc_q[$];
  logic          beat_last_q[$];
  logic [DW-1:0] beat_data_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [9:0]    prev_row = '0;
  logic          prev_last = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      occ        <= 0;
      prev_stall <= 1'b0;
    end else if (clr) begin
      rd_addr_q.delete(); rd_cyc_q.delete();
      beat_row_q.delete(); beat_cyc_q.delete(); beat_last_q.delete(); beat_data_q.delete();
      done_cnt  <= 0;
      max_occ   <= 0;
      stall_err <= 0;
    end else begin
      if (start_i && !busy_o) start_cyc <= cyc;
      if (rd_en) begin
        rd_addr_q.push_back(int'(rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid_o && out_ready_i) begin
        beat_row_q.push_back(int'(out_row_o));
        beat_cyc_q.push_back(cyc);
        beat_last_q.push_back(out_last_o);
        beat_data_q.push_back(out_data_o);
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      occ <= occ + int'(rd_en) - int'(out_valid_o && out_ready_i);
      if (occ + int'(rd_en) - int'(out_valid_o && out_ready_i) > max_occ)
        max_occ <= occ + int'(rd_en) - int'(out_valid_o && out_ready_i);
      if (prev_stall && !(out_valid_o && out_data_o === prev_data &&
                          out_row_o === prev_row && out_last_o === prev_last))
        stall_err <= stall_err + 1;
      prev_stall <= out_valid_o && !out_ready_i;
      prev_data  <= out_data_o;
      prev_row   <= out_row_o;
      prev_last  <= out_last_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] base, input logic [9:0] rows);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr         = 1'b0;
    base_addr_i = base;
    num_rows_i  = rows;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget, input logic toggle);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      if (toggle) out_ready_i = ~out_ready_i;
      k++;
    end
    out_ready_i = 1'b1;
    checkOutput("done_within_budget", DW'(k < budget), DW'(1));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},  DW'(busy_o),      '0);
    checkOutput({tag, "_done"},  DW'(done_o),      '0);
    checkOutput({tag, "_rden"},  DW'(rd_en),       '0);
    checkOutput({tag, "_addr"},  DW'(rd_addr),     '0);
    checkOutput({tag, "_valid"}, DW'(out_valid_o), '0);
    checkOutput({tag, "_data"},  out_data_o,       '0);
    checkOutput({tag, "_row"},   DW'(out_row_o),   '0);
    checkOutput({tag, "_last"},  DW'(out_last_o),  '0);
  endtask

  task automatic checkBeats(input string tag, input int base, input int rows);
    checkOutput({tag, "_beat_count"}, DW'(beat_row_q.size()), DW'(rows));
    checkOutput({tag, "_read_count"}, DW'(rd_addr_q.size()),  DW'(rows));
    for (int i = 0; i < rows && i < beat_row_q.size() && i < rd_addr_q.size(); i++) begin
      checkOutput({tag, "_rd_addr"}, DW'(rd_addr_q[i]),   DW'((base + i) % 1024));
      checkOutput({tag, "_row"},     DW'(beat_row_q[i]),  DW'(i));
      checkOutput({tag, "_last"},    DW'(beat_last_q[i]), DW'(i == rows - 1));
      checkOutput({tag, "_data"},    beat_data_q[i],      rowData((base + i) % 1024));
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkIdleOutputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("after_reset");

    // Basic drain with exact cycle timing.
    applyStimulus(10'd0, 10'd8);
    waitDone(100, 1'b0);
    checkBeats("basic", 0, 8);
    for (int i = 0; i < 8 && i < rd_cyc_q.size() && i < beat_cyc_q.size(); i++) begin
      checkOutput("basic_rd_cycle",   DW'(rd_cyc_q[i]),   DW'(start_cyc + 1 + i));
      checkOutput("basic_beat_cycle", DW'(beat_cyc_q[i]), DW'(start_cyc + 4 + i));
    end
    checkOutput("basic_done_cycle", DW'(done_cyc), DW'(start_cyc + 12));
    checkOutput("basic_done_once",  DW'(done_cnt), DW'(1));
    checkOutput("basic_busy_fall",  DW'(busy_o),   DW'(0));

    // Backpressure plus an ignored mid-command start.
    applyStimulus(10'd100, 10'd16);
    base_addr_i = 10'd7;
    num_rows_i  = 10'd3;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    waitDone(300, 1'b1);
    checkBeats("bp", 100, 16);
    checkOutput("bp_stall_stable", DW'(stall_err), DW'(0));
    checkOutput("bp_credit_bound", DW'(max_occ <= 4), DW'(1));
    checkOutput("bp_done_once",    DW'(done_cnt), DW'(1));

    // Address wrap.
    applyStimulus(10'd1020, 10'd6);
    waitDone(100, 1'b0);
    checkBeats("wrap", 1020, 6);

    // Zero-length command.
    applyStimulus(10'd33, 10'd0);
    waitDone(20, 1'b0);
    checkOutput("zero_done_cycle", DW'(done_cyc), DW'(start_cyc + 1));
    checkOutput("zero_reads",      DW'(rd_addr_q.size()),  DW'(0));
    checkOutput("zero_beats",      DW'(beat_row_q.size()), DW'(0));

    // Reset mid-command, then a fresh command.
    applyStimulus(10'd200, 10'd10);
    for (int k = 0; k < 50 && beat_row_q.size() < 3; k++) @(negedge clk);
    checkOutput("rst_reached_3_beats", DW'(beat_row_q.size()), DW'(3));
    rst = 1'b1;
    #1;
    checkIdleOutputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rst_no_done", DW'(done_cnt), DW'(0));
    checkOutput("rst_idle",    DW'(busy_o),   DW'(0));
    applyStimulus(10'd300, 10'd5);
    waitDone(100, 1'b0);
    checkBeats("post_rst", 300, 5);

    // Signed lanes through the optional clamp.
    applyStimulus(10'd500, 10'd1);
    waitDone(50, 1'b0);
    checkOutput("relu_beats", DW'(beat_row_q.size()), DW'(1));
    if (beat_data_q.size() > 0) begin
      checkOutput("relu_data", beat_data_q[0],         reluRowExpect());
      checkOutput("relu_row",  DW'(beat_row_q[0]),     DW'(0));
      checkOutput("relu_last", DW'(beat_last_q[0]),    DW'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
